// File: rtl/cpu.sv
// Five-stage in-order MIPS subset pipeline (IF, ID, EX, MEM, WB).
// Branches and jumps resolve in ID. Load-use and branch-operand hazards stall.
// Optional feature macro: CPU_MUL_EN enables the R-type mul instruction.
// Without the macro, mul decodes as a nop and no multiplier is built.

package cpu_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
endpackage

module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_en,
  input  logic [31:0] i_pc_next,
  output logic [31:0] pc_o
);
  // Program counter, cleared by reset and loaded whenever the fetch advances.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) pc_o <= '0;
    else if (i_en) pc_o <= i_pc_next;
endmodule

module cpu_imem (
  input  logic        clk_i,
  input  logic        i_we,
  input  logic [7:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_addr,
  output logic [31:0] o_instr
);
  logic [31:0] memory [0:255];
  // Load port is tied off in the core; program contents are preloaded externally.
  always @(posedge clk_i)
    if (i_we) memory[i_waddr] <= i_wdata;
  assign o_instr = memory[i_addr];
endmodule

module cpu_dmem (
  input  logic        clk_i,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0] memory [0:31];
  logic [4:0] w_a [0:3];
  // Byte lanes of a little-endian word; addresses wrap within the 32 bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_a[gi] = i_addr + 5'(gi);
    assign o_rdata[8*gi +: 8] = memory[w_a[gi]];
  end
  // Store writes all four bytes of the word in one cycle.
  always @(posedge clk_i)
    if (i_we) begin
      memory[w_a[0]] <= i_wdata[7:0];
      memory[w_a[1]] <= i_wdata[15:8];
      memory[w_a[2]] <= i_wdata[23:16];
      memory[w_a[3]] <= i_wdata[31:24];
    end
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra,
  input  logic [4:0]  i_rb,
  output logic [31:0] o_rd_a,
  output logic [31:0] o_rd_b
);
  logic [31:0] register [0:31];
  // Write-back; r0 is never written.
  always @(posedge clk_i)
    if (i_we && i_wa != 5'd0) register[i_wa] <= i_wd;
  // Same-cycle write-back is visible to ID reads (write-first behaviour).
  assign o_rd_a = (i_ra == 5'd0) ? 32'd0 : (i_we && i_wa == i_ra) ? i_wd : register[i_ra];
  assign o_rd_b = (i_rb == 5'd0) ? 32'd0 : (i_we && i_wa == i_rb) ? i_wd : register[i_rb];
endmodule

module cpu_control
  import cpu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_alu_src,
  output logic       o_reg_dst,
  output logic       Branch_o,
  output logic       Jump_o,
  output alu_op_e    o_alu_op
);
  // Main decoder; anything unrecognised leaves every control at 0 (nop).
  always_comb begin
    o_reg_write = 1'b0; o_mem_to_reg = 1'b0; o_mem_read = 1'b0; o_mem_write = 1'b0;
    o_alu_src = 1'b0; o_reg_dst = 1'b0; Branch_o = 1'b0; Jump_o = 1'b0; o_alu_op = ALU_ADD;
    case (i_op)
      6'b000000: begin
        o_reg_dst = 1'b1;
        case (i_funct)
          6'b100000: begin o_reg_write = 1'b1; o_alu_op = ALU_ADD; end
          6'b100010: begin o_reg_write = 1'b1; o_alu_op = ALU_SUB; end
          6'b100100: begin o_reg_write = 1'b1; o_alu_op = ALU_AND; end
          6'b100101: begin o_reg_write = 1'b1; o_alu_op = ALU_OR;  end
`ifdef CPU_MUL_EN
          6'b011000: begin o_reg_write = 1'b1; o_alu_op = ALU_MUL; end
`endif
          default: ;
        endcase
      end
      6'b001000: begin o_reg_write = 1'b1; o_alu_src = 1'b1; end
      6'b100011: begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_mem_read = 1'b1; o_mem_to_reg = 1'b1; end
      6'b101011: begin o_alu_src = 1'b1; o_mem_write = 1'b1; end
      6'b000100: Branch_o = 1'b1;
      6'b000010: Jump_o = 1'b1;
      default: ;
    endcase
  end
endmodule

module cpu_hazard (
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_branch,
  input  logic       i_ex_mem_read,
  input  logic       i_ex_reg_write,
  input  logic [4:0] i_ex_dst,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_dst,
  output logic       stall_o
);
  logic w_ex_hit, w_mem_hit;
  assign w_ex_hit  = (i_ex_dst != 5'd0) && (i_ex_dst == i_id_rs || i_ex_dst == i_id_rt);
  assign w_mem_hit = (i_mem_dst != 5'd0) && (i_mem_dst == i_id_rs || i_mem_dst == i_id_rt);
  // Stall on load-use, or while a beq operand is still in EX or MEM (no ID forwarding).
  always_comb begin
    stall_o = 1'b0;
    if (i_ex_mem_read && w_ex_hit) stall_o = 1'b1;
    if (i_branch && ((i_ex_reg_write && w_ex_hit) || (i_mem_reg_write && w_mem_hit))) stall_o = 1'b1;
  end
endmodule

module cpu
  import cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  logic [31:0] w_pc, w_pc4, w_pc_next, w_if_instr;
  logic [31:0] r_ifid_instr, r_ifid_pc4;
  logic [31:0] w_imm, w_rs_data, w_rt_data, w_br_target, w_j_target;
  logic [4:0]  w_rs, w_rt, w_dst;
  logic        w_rw, w_m2r, w_mr, w_mw, w_alusrc, w_regdst, w_branch, w_jump, w_stall, w_take;
  alu_op_e     w_aluop;
  logic        flush;
  logic        r_ex_rw, r_ex_m2r, r_ex_mr, r_ex_mw, r_ex_alusrc;
  alu_op_e     r_ex_aluop;
  logic [31:0] r_ex_a, r_ex_b, r_ex_imm;
  logic [4:0]  r_ex_rs, r_ex_rt, r_ex_dst;
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;
  logic        r_mem_rw, r_mem_m2r, r_mem_mw;
  logic [31:0] r_mem_alu, r_mem_wdata, w_mem_rdata;
  logic [4:0]  r_mem_dst;
  logic        r_wb_rw, r_wb_m2r;
  logic [31:0] r_wb_alu, r_wb_rdata, w_wb_data;
  logic [4:0]  r_wb_dst;

  // ---------------- IF ----------------
  assign w_pc4     = w_pc + 32'd4;
  assign w_pc_next = flush ? (w_jump ? w_j_target : w_br_target) : w_pc4;

  cpu_pc PC (.clk_i(clk_i), .rst_i(rst_i), .i_en(start_i & (flush | ~w_stall)),
             .i_pc_next(w_pc_next), .pc_o(w_pc));

  cpu_imem Instruction_Memory (.clk_i(clk_i), .i_we(1'b0), .i_waddr(8'd0), .i_wdata(32'd0),
                               .i_addr(w_pc[9:2]), .o_instr(w_if_instr));

  // IF/ID: flush replaces the fetched word with a nop and wins over a stall.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_ifid_instr <= '0; r_ifid_pc4 <= '0;
    end else if (start_i) begin
      if (flush) begin
        r_ifid_instr <= '0; r_ifid_pc4 <= '0;
      end else if (!w_stall) begin
        r_ifid_instr <= w_if_instr; r_ifid_pc4 <= w_pc4;
      end
    end

  // ---------------- ID ----------------
  assign w_rs  = r_ifid_instr[25:21];
  assign w_rt  = r_ifid_instr[20:16];
  assign w_imm = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_dst = w_regdst ? r_ifid_instr[15:11] : w_rt;

  cpu_control Control (.i_op(r_ifid_instr[31:26]), .i_funct(r_ifid_instr[5:0]),
                       .o_reg_write(w_rw), .o_mem_to_reg(w_m2r), .o_mem_read(w_mr),
                       .o_mem_write(w_mw), .o_alu_src(w_alusrc), .o_reg_dst(w_regdst),
                       .Branch_o(w_branch), .Jump_o(w_jump), .o_alu_op(w_aluop));

  cpu_regfile Registers (.clk_i(clk_i), .i_we(r_wb_rw & start_i), .i_wa(r_wb_dst), .i_wd(w_wb_data),
                         .i_ra(w_rs), .i_rb(w_rt), .o_rd_a(w_rs_data), .o_rd_b(w_rt_data));

  cpu_hazard HD (.i_id_rs(w_rs), .i_id_rt(w_rt), .i_branch(w_branch),
                 .i_ex_mem_read(r_ex_mr), .i_ex_reg_write(r_ex_rw), .i_ex_dst(r_ex_dst),
                 .i_mem_reg_write(r_mem_rw), .i_mem_dst(r_mem_dst), .stall_o(w_stall));

  assign w_br_target = r_ifid_pc4 + {w_imm[29:0], 2'b00};
  assign w_j_target  = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
  // A stalled beq is not resolved until its operands are settled.
  assign w_take      = w_branch & ~w_stall & (w_rs_data == w_rt_data);
  assign flush       = w_take | w_jump;

  // ID/EX: a stall injects a bubble with every control cleared.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_ex_rw <= 1'b0; r_ex_m2r <= 1'b0; r_ex_mr <= 1'b0; r_ex_mw <= 1'b0; r_ex_alusrc <= 1'b0;
      r_ex_aluop <= ALU_ADD; r_ex_a <= '0; r_ex_b <= '0; r_ex_imm <= '0;
      r_ex_rs <= '0; r_ex_rt <= '0; r_ex_dst <= '0;
    end else if (start_i) begin
      r_ex_rw <= w_rw & ~w_stall; r_ex_m2r <= w_m2r & ~w_stall;
      r_ex_mr <= w_mr & ~w_stall; r_ex_mw <= w_mw & ~w_stall;
      r_ex_alusrc <= w_alusrc; r_ex_aluop <= w_aluop;
      r_ex_a <= w_rs_data; r_ex_b <= w_rt_data; r_ex_imm <= w_imm;
      r_ex_rs <= w_rs; r_ex_rt <= w_rt; r_ex_dst <= w_dst;
    end

  // ---------------- EX ----------------
  // Operand forwarding: EX/MEM first, then MEM/WB, never for r0.
  always_comb begin
    w_fwd_a = r_ex_a;
    w_fwd_b = r_ex_b;
    if (r_wb_rw && r_wb_dst != 5'd0 && r_wb_dst == r_ex_rs) w_fwd_a = w_wb_data;
    if (r_mem_rw && r_mem_dst != 5'd0 && r_mem_dst == r_ex_rs) w_fwd_a = r_mem_alu;
    if (r_wb_rw && r_wb_dst != 5'd0 && r_wb_dst == r_ex_rt) w_fwd_b = w_wb_data;
    if (r_mem_rw && r_mem_dst != 5'd0 && r_mem_dst == r_ex_rt) w_fwd_b = r_mem_alu;
  end
  assign w_alu_b = r_ex_alusrc ? r_ex_imm : w_fwd_b;

  // ALU; results wrap at 32 bits.
  always_comb begin
    w_alu_res = '0;
    case (r_ex_aluop)
      ALU_ADD: w_alu_res = w_fwd_a + w_alu_b;
      ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
      ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
      ALU_OR:  w_alu_res = w_fwd_a | w_alu_b;
`ifdef CPU_MUL_EN
      ALU_MUL: w_alu_res = w_fwd_a * w_alu_b;
`endif
      default: w_alu_res = '0;
    endcase
  end

  // EX/MEM register.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_mem_rw <= 1'b0; r_mem_m2r <= 1'b0; r_mem_mw <= 1'b0;
      r_mem_alu <= '0; r_mem_wdata <= '0; r_mem_dst <= '0;
    end else if (start_i) begin
      r_mem_rw <= r_ex_rw; r_mem_m2r <= r_ex_m2r; r_mem_mw <= r_ex_mw;
      r_mem_alu <= w_alu_res; r_mem_wdata <= w_fwd_b; r_mem_dst <= r_ex_dst;
    end

  // ---------------- MEM ----------------
  cpu_dmem Data_Memory (.clk_i(clk_i), .i_we(r_mem_mw & start_i), .i_addr(r_mem_alu[4:0]),
                        .i_wdata(r_mem_wdata), .o_rdata(w_mem_rdata));

  // MEM/WB register.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wb_rw <= 1'b0; r_wb_m2r <= 1'b0; r_wb_alu <= '0; r_wb_rdata <= '0; r_wb_dst <= '0;
    end else if (start_i) begin
      r_wb_rw <= r_mem_rw; r_wb_m2r <= r_mem_m2r; r_wb_alu <= r_mem_alu;
      r_wb_rdata <= w_mem_rdata; r_wb_dst <= r_mem_dst;
    end

  // ---------------- WB ----------------
  assign w_wb_data = r_wb_m2r ? r_wb_rdata : r_wb_alu;
endmodule

// File: tb/tb_cpu.sv
// Directed testbench for the cpu pipeline: reset/hold, load latency,
// forwarding, load-use stall, branch/jump flush, branch-operand stall, mul.
`timescale 1ns/1ps
module tb_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  int total = 0;
  int bad = 0;
  int stall_cnt, flush_cnt, sb_cnt;
  logic [31:0] v;

  cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Hold reset, clear program/data memories, preload registers with tags.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = 8'd0;
    dut.Registers.register[0] = 32'd0;
    for (int i = 1; i < 32; i++) dut.Registers.register[i] = 32'h0BAD_0000 | i;
    @(negedge clk_i);
  endtask

  task automatic release_rst(input logic s);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = s;
    stall_cnt = 0; flush_cnt = 0; sb_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (dut.HD.stall_o) stall_cnt++;
      if (dut.flush) flush_cnt++;
      if (dut.HD.stall_o && dut.Control.Branch_o) sb_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h04, 0, 0, 0);
    total++; if (dut.PC.pc_o !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", dut.PC.pc_o); end
    total++; if (dut.HD.stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", dut.HD.stall_o); end
    total++; if (dut.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", dut.flush); end
    release_rst(1'b0);
    step(3);
    total++; if (dut.PC.pc_o !== 32'd0) begin bad++; $display("FAIL hold_pc got=%h want=0", dut.PC.pc_o); end
    start_i = 1'b1;
    step(1);
    total++; if (dut.PC.pc_o !== 32'd4) begin bad++; $display("FAIL first_fetch_pc got=%h want=4", dut.PC.pc_o); end
    total++; if (dut.flush !== 1'b1) begin bad++; $display("FAIL beq0_flush got=%b want=1", dut.flush); end
    #2 rst_i = 1'b0;
    #1;
    total++; if (dut.PC.pc_o !== 32'd0) begin bad++; $display("FAIL async_pc got=%h want=0", dut.PC.pc_o); end
    total++; if (dut.flush !== 1'b0) begin bad++; $display("FAIL async_flush got=%b want=0", dut.flush); end
    $display("test_reset done");
  endtask

  task automatic test_load();
    do_reset();
    dut.Data_Memory.memory[0] = 8'd5;
    dut.Instruction_Memory.memory[0] = enc_i(6'h23, 0, 8, 0);
    release_rst(1'b1);
    step(4);
    total++; if (dut.Registers.register[8] !== 32'h0BAD_0008) begin bad++; $display("FAIL lw_early got=%h want=0bad0008", dut.Registers.register[8]); end
    step(1);
    total++; if (dut.Registers.register[8] !== 32'd5) begin bad++; $display("FAIL lw_t0 got=%h want=5", dut.Registers.register[8]); end
    total++; if (dut.PC.pc_o !== 32'd20) begin bad++; $display("FAIL lw_pc got=%h want=20", dut.PC.pc_o); end
    $display("test_load done t0=%0d pc=%0d", dut.Registers.register[8], dut.PC.pc_o);
  endtask

  task automatic test_forward();
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 0, 9, 3);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 9, 10, 4);
    release_rst(1'b1);
    step(8);
    total++; if (dut.Registers.register[10] !== 32'd7) begin bad++; $display("FAIL fwd_t2 got=%h want=7", dut.Registers.register[10]); end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL fwd_stalls got=%0d want=0", stall_cnt); end
    $display("test_forward done t2=%0d stalls=%0d", dut.Registers.register[10], stall_cnt);
  endtask

  task automatic test_alu();
    do_reset();
    dut.Instruction_Memory.memory[0]  = enc_i(6'h08, 0, 8, 12);
    dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 0, 9, 10);
    dut.Instruction_Memory.memory[2]  = enc_r(8, 9, 10, 6'b100010);
    dut.Instruction_Memory.memory[3]  = enc_r(8, 9, 11, 6'b100100);
    dut.Instruction_Memory.memory[4]  = enc_r(8, 9, 12, 6'b100101);
    dut.Instruction_Memory.memory[5]  = enc_i(6'h08, 0, 13, -1);
    dut.Instruction_Memory.memory[6]  = enc_r(13, 8, 14, 6'b100000);
    dut.Instruction_Memory.memory[7]  = enc_i(6'h2B, 0, 13, 30);
    dut.Instruction_Memory.memory[8]  = enc_i(6'h23, 0, 15, 30);
    dut.Instruction_Memory.memory[9]  = enc_i(6'h08, 0, 0, 5);
    dut.Instruction_Memory.memory[10] = enc_i(6'h08, 0, 24, 1);
    release_rst(1'b1);
    step(16);
    total++; if (dut.Registers.register[10] !== 32'd2) begin bad++; $display("FAIL sub got=%h want=2", dut.Registers.register[10]); end
    total++; if (dut.Registers.register[11] !== 32'd8) begin bad++; $display("FAIL and got=%h want=8", dut.Registers.register[11]); end
    total++; if (dut.Registers.register[12] !== 32'd14) begin bad++; $display("FAIL or got=%h want=e", dut.Registers.register[12]); end
    total++; if (dut.Registers.register[13] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_neg got=%h want=ffffffff", dut.Registers.register[13]); end
    total++; if (dut.Registers.register[14] !== 32'd11) begin bad++; $display("FAIL add_wrap got=%h want=b", dut.Registers.register[14]); end
    total++; if (dut.Registers.register[15] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lw_wrap got=%h want=ffffffff", dut.Registers.register[15]); end
    v = {24'd0, dut.Data_Memory.memory[1]};
    total++; if (v !== 32'hFF) begin bad++; $display("FAIL sw_wrap_byte1 got=%h want=ff", v); end
    total++; if (dut.Registers.register[0] !== 32'd0) begin bad++; $display("FAIL r0 got=%h want=0", dut.Registers.register[0]); end
    total++; if (dut.Registers.register[24] !== 32'd1) begin bad++; $display("FAIL r0_nofwd got=%h want=1", dut.Registers.register[24]); end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL alu_stalls got=%0d want=0", stall_cnt); end
    $display("test_alu done t7=%h stalls=%0d", dut.Registers.register[15], stall_cnt);
  endtask

  task automatic test_load_use();
    do_reset();
    dut.Data_Memory.memory[0] = 8'd5;
    dut.Instruction_Memory.memory[0] = enc_i(6'h23, 0, 8, 0);
    dut.Instruction_Memory.memory[1] = enc_r(8, 8, 9, 6'b100000);
    release_rst(1'b1);
    step(10);
    total++; if (stall_cnt !== 1) begin bad++; $display("FAIL lu_stalls got=%0d want=1", stall_cnt); end
    total++; if (dut.Registers.register[9] !== 32'd10) begin bad++; $display("FAIL lu_t1 got=%h want=a", dut.Registers.register[9]); end
    $display("test_load_use done stalls=%0d t1=%0d", stall_cnt, dut.Registers.register[9]);
  endtask

  task automatic test_beq();
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h04, 0, 0, 2);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 0, 9, 1);
    dut.Instruction_Memory.memory[2] = enc_i(6'h08, 0, 10, 2);
    dut.Instruction_Memory.memory[3] = enc_i(6'h08, 0, 11, 3);
    release_rst(1'b1);
    step(2);
    total++; if (dut.PC.pc_o !== 32'd12) begin bad++; $display("FAIL beq_pc got=%h want=c", dut.PC.pc_o); end
    step(8);
    total++; if (flush_cnt !== 1) begin bad++; $display("FAIL beq_flushes got=%0d want=1", flush_cnt); end
    total++; if (dut.Registers.register[9] !== 32'h0BAD_0009) begin bad++; $display("FAIL beq_skip got=%h want=0bad0009", dut.Registers.register[9]); end
    total++; if (dut.Registers.register[11] !== 32'd3) begin bad++; $display("FAIL beq_target got=%h want=3", dut.Registers.register[11]); end
    $display("test_beq done flushes=%0d", flush_cnt);
  endtask

  task automatic test_beq_stall();
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 0, 8, 1);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 0, 9, 1);
    dut.Instruction_Memory.memory[2] = enc_i(6'h04, 8, 9, 1);
    dut.Instruction_Memory.memory[3] = enc_i(6'h08, 0, 10, 5);
    dut.Instruction_Memory.memory[4] = enc_i(6'h08, 0, 11, 6);
    release_rst(1'b1);
    step(14);
    total++; if (sb_cnt !== 2) begin bad++; $display("FAIL bstall_cycles got=%0d want=2", sb_cnt); end
    total++; if (flush_cnt !== 1) begin bad++; $display("FAIL bstall_flush got=%0d want=1", flush_cnt); end
    total++; if (dut.Registers.register[10] !== 32'h0BAD_000A) begin bad++; $display("FAIL bstall_skip got=%h want=0bad000a", dut.Registers.register[10]); end
    total++; if (dut.Registers.register[11] !== 32'd6) begin bad++; $display("FAIL bstall_target got=%h want=6", dut.Registers.register[11]); end
    $display("test_beq_stall done stalls=%0d flushes=%0d", sb_cnt, flush_cnt);
  endtask

  task automatic test_jump();
    do_reset();
    dut.Instruction_Memory.memory[0] = {6'b000010, 26'd4};
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 0, 9, 1);
    dut.Instruction_Memory.memory[4] = enc_i(6'h08, 0, 10, 2);
    release_rst(1'b1);
    step(2);
    total++; if (dut.PC.pc_o !== 32'h10) begin bad++; $display("FAIL j_pc got=%h want=10", dut.PC.pc_o); end
    step(8);
    total++; if (flush_cnt !== 1) begin bad++; $display("FAIL j_flushes got=%0d want=1", flush_cnt); end
    total++; if (dut.Registers.register[9] !== 32'h0BAD_0009) begin bad++; $display("FAIL j_skip got=%h want=0bad0009", dut.Registers.register[9]); end
    total++; if (dut.Registers.register[10] !== 32'd2) begin bad++; $display("FAIL j_target got=%h want=2", dut.Registers.register[10]); end
    $display("test_jump done flushes=%0d", flush_cnt);
  endtask

  task automatic test_mul();
    logic [31:0] exp;
`ifdef CPU_MUL_EN
    exp = 32'd21;
`else
    exp = 32'h0BAD_000B;
`endif
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 0, 9, 3);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 0, 10, 7);
    dut.Instruction_Memory.memory[2] = enc_r(9, 10, 11, 6'b011000);
    release_rst(1'b1);
    step(10);
    total++; if (dut.Registers.register[11] !== exp) begin bad++; $display("FAIL mul_t3 got=%h want=%h", dut.Registers.register[11], exp); end
    $display("test_mul done t3=%h", dut.Registers.register[11]);
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_alu();
    test_load_use();
    test_beq();
    test_beq_stall();
    test_jump();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 = clock (all state on rising edge); rst_i input 1 = reset, 0 asserts immediately, 1 releases.
REQ-002 start_i input 1 SHALL be run enable: when 1 the PC advances; when 0 the PC holds.
REQ-003 The block SHALL have no other top-level ports; results are read through named internal state.
REQ-004 Observable internal state SHALL use these fixed hierarchical names:
- Instruction_Memory.memory: 256 x 32-bit words, read-only, indexed by pc[9:2].
- Data_Memory.memory: 32 x 8-bit bytes, little-endian words.
- Registers.register: 32 x 32-bit.
- PC.pc_o: 32-bit current PC.
- HD.stall_o: 1-bit load-use stall.
- Control.Jump_o, Control.Branch_o: 1-bit decode outputs.
- flush: 1-bit top-level IF/ID flush.

Function
REQ-005 The CPU SHALL be a 5-stage in-order pipeline: IF, ID, EX, MEM, WB, with 1 instruction per cycle when no hazard occurs.
REQ-006 Supported MIPS encodings SHALL be:
- R-type (op 000000): add funct 100000, sub 100010, and 100100, or 100101, mul 011000.
- addi (001000), lw (100011), sw (101011), beq (000100), j (000010).
- All other encodings execute as nop.
REQ-007 Arithmetic SHALL be 32-bit two's complement with overflow ignored; mul keeps the low 32 bits; immediates are sign-extended.
REQ-008 Register 0 SHALL read 0 and never be written.
REQ-009 WB SHALL write in the first half-cycle, so an ID read of the same register in the same cycle returns the new value.
REQ-010 Forwarding SHALL supply EX operands from EX/MEM and then MEM/WB, with EX/MEM taking priority; no forwarding from or to r0.
REQ-011 Load-use hazard: when the ID instruction reads the rt of a lw in EX, HD.stall_o SHALL be 1 for exactly one cycle.
- PC and IF/ID hold.
- A bubble (all controls 0) enters ID/EX.
REQ-012 beq SHALL be resolved in ID: equality compare, target = pc+4 + (sext(imm)<<2).
REQ-013 j SHALL be resolved in ID: target = {pc+4[31:28], imm26, 2'b00}.
REQ-014 On a taken beq or a j, flush SHALL be 1 for that cycle; the next PC is the target and the instruction in IF is replaced by a nop.
REQ-015 A beq whose operand comes from an instruction still in the pipeline SHALL stall until the operand is available; this uses the same HD.stall_o and applies with Branch_o=1.
REQ-016 lw and sw SHALL use word address = rs + sext(imm), with bytes addr..addr+3 in little-endian order.
REQ-017 Addresses at or above 32 SHALL wrap modulo 32.
REQ-018 PC SHALL wrap modulo 1024 bytes (256 words) when indexing instruction memory.
REQ-019 When stall and flush are both 1, the flush SHALL take priority.

Reset
REQ-020 While rst_i=0, the following SHALL be 0: PC and all pipeline registers (contents become nops), HD.stall_o, and flush.
REQ-021 Reset SHALL NOT clear the register file, instruction memory or data memory.
REQ-022 After release with start_i=1, the first fetch SHALL be at PC 0 on the next rising edge.

Configuration
REQ-023 With CPU_MUL_EN defined, mul SHALL execute as in REQ-006 and REQ-007.
REQ-024 Without CPU_MUL_EN, the mul encoding SHALL execute as a nop (no register write) and the multiplier SHALL be absent from the RTL.

Verification
REQ-025 Reset then start: data memory 0x00=5, instruction lw $t0,0($0) -> after 5 cycles t0=5 and PC=20.
REQ-026 addi $t1,$0,3; addi $t2,$t1,4 back-to-back -> t2=7 via forwarding, with stall count 0.
REQ-027 lw $t0,0($0); add $t1,$t0,$t0 with mem[0]=5 -> exactly one HD.stall_o cycle and t1=10.
REQ-028 beq $0,$0,+2 -> flush=1 for one cycle, the next sequential instruction is not executed, and PC reaches branch pc+12.
REQ-029 j 0x10 at PC 0 -> flush count 1 and the instruction at PC 4 has no effect.
REQ-030 CPU_MUL_EN defined, mul $t3,$t1,$t2 with 3 and 7 -> t3=21; undefined -> t3 unchanged.
